ahb_slave_if: RTL and testbench

AHB-Lite slave front end of the AHB-to-APB bridge: the responder to the AHB master's NONSEQ/SEQ single transfers. It decodes the address into one of three APB peripheral slots and registers the address and control phase, then the write data. It issues one request per transfer to the APB back end over a valid/done handshake and holds `Hreadyout` low until that request completes. Read data and response status return to the master.

---
 rtl/ahb_slave_if_if.sv | 29 ++
 rtl/ahb_slave_if.sv | 160 ++++++++++++++++
 tb/tb_ahb_slave_if.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB-Lite master, the bridge slave front end and the APB back end.
// The slave modport is the bridge's view; the master modport drives AHB inputs and the back-end replies.
interface ahb_slave_if_if;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_sel;
    logic        req_done;
    logic [31:0] req_rdata;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_done, req_rdata,
        output Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_done, req_rdata,
        input  Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel
    );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: decode, capture, one back-end request per transfer.
// Define AHB_ERR_RESP_EN to answer unmapped transfers with the two-cycle ERROR response.
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLOT_SIZE = 32'h0400_0000
) (
    input  logic            Hclk,
    input  logic            Hreset,
    ahb_slave_if_if.slave   bus
);
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned NSEL = 3;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AHB_ERR_RESP_EN
    localparam logic [1:0]  RESP_ERR  = 2'b01;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT
`ifdef AHB_ERR_RESP_EN
        , S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              hreadyout_q, hreadyout_d;
    logic [1:0]        hresp_q, hresp_d;
    logic [DW-1:0]     hrdata_q, hrdata_d;
    logic              req_valid_q, req_valid_d;
    logic              req_write_q, req_write_d;
    logic [AW-1:0]     req_addr_q, req_addr_d;
    logic [DW-1:0]     req_wdata_q, req_wdata_d;
    logic [NSEL-1:0]   req_sel_q, req_sel_d;

    logic [AW-1:0]     offset_c;
    logic [NSEL-1:0]   sel_c;
    logic              xfer_c;

    // Slot decode; addresses below the base would wrap the offset, so they are excluded first
    assign offset_c = bus.Haddr - BASE_ADDR;
    always_comb begin
        sel_c = '0;
        if (bus.Haddr >= BASE_ADDR) begin
            if (offset_c < SLOT_SIZE)
                sel_c = NSEL'(3'b001);
            else if (offset_c < SLOT_SIZE + SLOT_SIZE)
                sel_c = NSEL'(3'b010);
            else if (offset_c < SLOT_SIZE + SLOT_SIZE + SLOT_SIZE)
                sel_c = NSEL'(3'b100);
        end
    end

    assign xfer_c = bus.Hreadyin && (bus.Htrans inside {2'b10, 2'b11}) && hreadyout_q;

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            hrdata_q    <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_sel_q   <= req_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer_c && (sel_c != '0))
                    state_d = S_DATA;
`ifdef AHB_ERR_RESP_EN
                else if (xfer_c)
                    state_d = S_ERR1;
`endif
            end
            S_DATA: state_d = S_WAIT;
            S_WAIT: if (bus.req_done) state_d = S_IDLE;
`ifdef AHB_ERR_RESP_EN
            S_ERR1: state_d = S_ERR2;
            S_ERR2: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a state says otherwise
    always_comb begin
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_sel_d   = req_sel_q;
        case (state_q)
            S_IDLE: begin
                if (xfer_c && (sel_c != '0)) begin
                    req_addr_d  = bus.Haddr;
                    req_write_d = bus.Hwrite;
                    req_sel_d   = sel_c;
                    hreadyout_d = 1'b0;
                end
`ifdef AHB_ERR_RESP_EN
                else if (xfer_c) begin
                    hreadyout_d = 1'b0;
                    hresp_d     = RESP_ERR;
                end
`endif
            end
            S_DATA: begin
                req_wdata_d = bus.Hwdata;
                req_valid_d = 1'b1;
            end
            S_WAIT: begin
                if (bus.req_done) begin
                    req_valid_d = 1'b0;
                    hreadyout_d = 1'b1;
                    if (!req_write_q)
                        hrdata_d = bus.req_rdata;
                end
            end
`ifdef AHB_ERR_RESP_EN
            S_ERR1: hreadyout_d = 1'b1;
            S_ERR2: hresp_d     = RESP_OKAY;
`endif
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
            end
        endcase
    end

    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_write = req_write_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
    assign bus.req_sel   = req_sel_q;
endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for the AHB slave front end: reset, single transfers, decode, ignored cycles, unmapped, mid-WAIT reset.
module tb_ahb_slave_if;
    logic Hclk;
    logic Hreset;
    int   total;
    int   bad;
    int   waits;

    ahb_slave_if_if bus ();

    ahb_slave_if dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    // One NONSEQ transfer; n_low WAIT cycles see req_done=0 before it rises (n_low<0: req_done tied high)
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int n_low, output int nwait);
        int lowcnt;
        bus.Htrans    = 2'b10;
        bus.Haddr     = addr;
        bus.Hwrite    = wr;
        bus.Hreadyin  = 1'b1;
        bus.req_rdata = rdata;
        bus.req_done  = (n_low < 0);
        tick();
        bus.Htrans = 2'b00;
        bus.Hwdata = wdata;
        nwait  = 0;
        lowcnt = 0;
        while (bus.Hreadyout == 1'b0 && nwait < 50) begin
            nwait++;
            if (bus.req_valid && n_low >= 0) begin
                if (lowcnt == n_low) bus.req_done = 1'b1;
                lowcnt++;
            end
            tick();
        end
        bus.req_done = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Hreset        = 1'b0;
        bus.Hwrite    = 1'b0;
        bus.Hreadyin  = 1'b1;
        bus.Htrans    = 2'b00;
        bus.Haddr     = '0;
        bus.Hwdata    = '0;
        bus.req_done  = 1'b0;
        bus.req_rdata = '0;

        #2 Hreset = 1'b1;
        tick();
        tick();
        check("rst_hreadyout", 32'(bus.Hreadyout), 32'd1);
        check("rst_hresp",     32'(bus.Hresp),     32'd0);
        check("rst_hrdata",    bus.Hrdata,         32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_req_sel",   32'(bus.req_sel),   32'd0);
        check("rst_req_addr",  bus.req_addr,       32'd0);
        Hreset = 1'b0;
        tick();

        // single write, req_done tied high
        run_xfer(32'h8000_0001, 1'b1, 32'h0000_00A3, 32'h0, -1, waits);
        check("wr_waits",     32'(waits),         32'd2);
        check("wr_sel",       32'(bus.req_sel),   32'd1);
        check("wr_addr",      bus.req_addr,       32'h8000_0001);
        check("wr_wdata",     bus.req_wdata,      32'h0000_00A3);
        check("wr_write",     32'(bus.req_write), 32'd1);
        check("wr_hresp",     32'(bus.Hresp),     32'd0);
        check("wr_valid_off", 32'(bus.req_valid), 32'd0);
        check("wr_hrdata",    bus.Hrdata,         32'd0);

        // single read with two WAIT cycles before done
        run_xfer(32'h8000_00A2, 1'b0, 32'h0, 32'h0000_005A, 2, waits);
        check("rd_waits",  32'(waits),         32'd4);
        check("rd_hrdata", bus.Hrdata,         32'h0000_005A);
        check("rd_write",  32'(bus.req_write), 32'd0);
        check("rd_sel",    32'(bus.req_sel),   32'd1);
        bus.req_rdata = 32'h1111_2222;
        tick();
        tick();
        tick();
        check("rd_hold", bus.Hrdata, 32'h0000_005A);

        // back-to-back writes to slots 2 and 3
        run_xfer(32'h8400_0010, 1'b1, 32'h0000_0011, 32'h0, 0, waits);
        check("s2_waits", 32'(waits),       32'd2);
        check("s2_sel",   32'(bus.req_sel), 32'd2);
        check("s2_addr",  bus.req_addr,     32'h8400_0010);
        run_xfer(32'h8800_0020, 1'b1, 32'h0000_0022, 32'h0, 0, waits);
        check("s3_waits",  32'(waits),       32'd2);
        check("s3_sel",    32'(bus.req_sel), 32'd4);
        check("s3_wdata",  bus.req_wdata,    32'h0000_0022);
        check("s3_hrdata", bus.Hrdata,       32'h0000_005A);

        // IDLE, BUSY and NONSEQ without Hreadyin are all ignored
        for (int i = 0; i < 3; i++) begin
            bus.Haddr    = 32'h8000_0040;
            bus.Hwrite   = 1'b1;
            bus.Htrans   = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10;
            bus.Hreadyin = (i != 2);
            tick();
            check("ign_hreadyout", 32'(bus.Hreadyout), 32'd1);
            tick();
            check("ign_req_valid", 32'(bus.req_valid), 32'd0);
            check("ign_req_addr",  bus.req_addr,       32'h8800_0020);
        end
        bus.Htrans   = 2'b00;
        bus.Hreadyin = 1'b1;
        tick();

        // unmapped read
        bus.req_rdata = 32'h0000_DEAD;
        bus.req_done  = 1'b1;
        bus.Haddr     = 32'h9000_0000;
        bus.Hwrite    = 1'b0;
        bus.Htrans    = 2'b10;
        tick();
        bus.Htrans = 2'b00;
`ifdef AHB_ERR_RESP_EN
        check("um_e1_hreadyout", 32'(bus.Hreadyout), 32'd0);
        check("um_e1_hresp",     32'(bus.Hresp),     32'd1);
        tick();
        check("um_e2_hreadyout", 32'(bus.Hreadyout), 32'd1);
        check("um_e2_hresp",     32'(bus.Hresp),     32'd1);
        check("um_e2_valid",     32'(bus.req_valid), 32'd0);
        tick();
        check("um_end_hresp",    32'(bus.Hresp),     32'd0);
`else
        check("um_hreadyout", 32'(bus.Hreadyout), 32'd1);
        check("um_hresp",     32'(bus.Hresp),     32'd0);
        tick();
        check("um_valid",     32'(bus.req_valid), 32'd0);
`endif
        tick();
        check("um_req_valid", 32'(bus.req_valid), 32'd0);
        check("um_hrdata",    bus.Hrdata,         32'h0000_005A);
        check("um_req_addr",  bus.req_addr,       32'h8800_0020);
        bus.req_done = 1'b0;

        // reset asserted while the request waits for done
        bus.Haddr  = 32'h8000_0100;
        bus.Hwrite = 1'b0;
        bus.Htrans = 2'b10;
        tick();
        bus.Htrans = 2'b00;
        tick();
        check("mw_req_valid_pre", 32'(bus.req_valid), 32'd1);
        #2 Hreset = 1'b1;
        #1;
        check("mw_req_valid", 32'(bus.req_valid), 32'd0);
        check("mw_hreadyout", 32'(bus.Hreadyout), 32'd1);
        check("mw_hresp",     32'(bus.Hresp),     32'd0);
        check("mw_hrdata",    bus.Hrdata,         32'd0);
        check("mw_req_addr",  bus.req_addr,       32'd0);
        tick();
        Hreset = 1'b0;
        bus.req_done = 1'b1;
        tick();
        tick();
        check("mw_no_retry", 32'(bus.req_valid), 32'd0);
        check("mw_idle_rdy", 32'(bus.Hreadyout), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
